reservation_station: RTL and testbench

Reservation station for non-memory instructions: the consumer of the issue stage's `RS_send` path. Holds up to `RS_SIZE` issued ALU and branch operations and captures missing operands from the two common data buses (ALU and load/store). Each cycle it dispatches one operation whose operands are both ready to the ALU. Sits between issue (upstream) and the ALU (downstream); flushed by `jump_rst` on a mispredict.

---
 rtl/reservation_station.sv | 184 ++++++++++++++++++
 tb/tb_reservation_station.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station for ALU/branch ops: issue into a free slot, capture operands from two CDBs, dispatch one ready op per cycle.
// Optional macro RS_AGE_SELECT_EN switches select from lowest-index to oldest-by-ROB-distance.
module reservation_station #(
  parameter int RS_SIZE      = 16,
  parameter int RS_SIZE_LOG  = 4,
  parameter int ROB_SIZE_LOG = 4,
  parameter int OP_SIZE_LOG  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    jump_rst,
  input  logic                    RS_send,
  input  logic [31:0]             Vj,
  input  logic [31:0]             Vk,
  input  logic [ROB_SIZE_LOG-1:0] Qj,
  input  logic [ROB_SIZE_LOG-1:0] Qk,
  input  logic                    Pj,
  input  logic                    Pk,
  input  logic [OP_SIZE_LOG-1:0]  issue_op,
  input  logic [31:0]             issue_imm,
  input  logic [31:0]             issue_curPC,
  input  logic [ROB_SIZE_LOG-1:0] issue_reorder,
  input  logic [ROB_SIZE_LOG-1:0] ROB_head,
  input  logic                    ALU_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] ALU_cdb_reorder,
  input  logic [31:0]             ALU_cdb_value,
  input  logic                    LSB_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] LSB_cdb_reorder,
  input  logic [31:0]             LSB_cdb_value,
  output logic                    RS_full,
  output logic                    ALU_valid,
  output logic [OP_SIZE_LOG-1:0]  ALU_op,
  output logic [31:0]             ALU_Vj,
  output logic [31:0]             ALU_Vk,
  output logic [31:0]             ALU_imm,
  output logic [31:0]             ALU_curPC,
  output logic [ROB_SIZE_LOG-1:0] ALU_reorder
);

  // Issue handshake: RS_send is valid, !RS_full is ready; an op transfers at an edge where
  // both hold with rdy=1 and no flush. There is no backpressure on the dispatch side.
  logic [RS_SIZE-1:0]      r_busy;
  logic [RS_SIZE-1:0]      r_pj;
  logic [RS_SIZE-1:0]      r_pk;
  logic [OP_SIZE_LOG-1:0]  r_op      [RS_SIZE];
  logic [31:0]             r_vj      [RS_SIZE];
  logic [31:0]             r_vk      [RS_SIZE];
  logic [31:0]             r_imm     [RS_SIZE];
  logic [31:0]             r_pc      [RS_SIZE];
  logic [ROB_SIZE_LOG-1:0] r_qj      [RS_SIZE];
  logic [ROB_SIZE_LOG-1:0] r_qk      [RS_SIZE];
  logic [ROB_SIZE_LOG-1:0] r_reorder [RS_SIZE];

  logic [RS_SIZE-1:0]     w_ready;
  logic                   w_sel_found;
  logic [RS_SIZE_LOG-1:0] w_sel_idx;
  logic [RS_SIZE_LOG-1:0] w_free_idx;
  logic                   w_issue;

  logic        w_j_alu_hit, w_j_lsb_hit, w_k_alu_hit, w_k_lsb_hit;
  logic        w_in_pj, w_in_pk;
  logic [31:0] w_in_vj, w_in_vk;

  assign RS_full = &r_busy;
  assign w_ready = r_busy & r_pj & r_pk;
  assign w_issue = RS_send && !RS_full;

  // Operands arriving on a CDB in the issue cycle are captured directly; ALU CDB wins a tie.
  assign w_j_alu_hit = !Pj && ALU_cdb_valid && (ALU_cdb_reorder == Qj);
  assign w_j_lsb_hit = !Pj && LSB_cdb_valid && (LSB_cdb_reorder == Qj);
  assign w_k_alu_hit = !Pk && ALU_cdb_valid && (ALU_cdb_reorder == Qk);
  assign w_k_lsb_hit = !Pk && LSB_cdb_valid && (LSB_cdb_reorder == Qk);
  assign w_in_pj = Pj || w_j_alu_hit || w_j_lsb_hit;
  assign w_in_pk = Pk || w_k_alu_hit || w_k_lsb_hit;
  assign w_in_vj = w_j_alu_hit ? ALU_cdb_value : (w_j_lsb_hit ? LSB_cdb_value : Vj);
  assign w_in_vk = w_k_alu_hit ? ALU_cdb_value : (w_k_lsb_hit ? LSB_cdb_value : Vk);

  always_comb begin
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = RS_SIZE_LOG'(i);
    end
  end

`ifdef RS_AGE_SELECT_EN
  always_comb begin : sel_age
    logic [ROB_SIZE_LOG-1:0] v_age;
    logic [ROB_SIZE_LOG-1:0] v_best;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    v_age       = '0;
    v_best      = '1;
    for (int i = 0; i < RS_SIZE; i++) begin
      v_age = r_reorder[i] - ROB_head;
      if (w_ready[i] && (!w_sel_found || (v_age < v_best))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = RS_SIZE_LOG'(i);
        v_best      = v_age;
      end
    end
  end
`else
  logic w_unused_head;
  assign w_unused_head = ^ROB_head;

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = RS_SIZE_LOG'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      ALU_valid   <= 1'b0;
      ALU_op      <= '0;
      ALU_Vj      <= '0;
      ALU_Vk      <= '0;
      ALU_imm     <= '0;
      ALU_curPC   <= '0;
      ALU_reorder <= '0;
    end else if (jump_rst) begin
      r_busy    <= '0;
      ALU_valid <= 1'b0;
    end else if (!rdy) begin
      ALU_valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && !r_pj[i]) begin
          if (ALU_cdb_valid && (ALU_cdb_reorder == r_qj[i])) begin
            r_vj[i] <= ALU_cdb_value;
            r_pj[i] <= 1'b1;
          end else if (LSB_cdb_valid && (LSB_cdb_reorder == r_qj[i])) begin
            r_vj[i] <= LSB_cdb_value;
            r_pj[i] <= 1'b1;
          end
        end
        if (r_busy[i] && !r_pk[i]) begin
          if (ALU_cdb_valid && (ALU_cdb_reorder == r_qk[i])) begin
            r_vk[i] <= ALU_cdb_value;
            r_pk[i] <= 1'b1;
          end else if (LSB_cdb_valid && (LSB_cdb_reorder == r_qk[i])) begin
            r_vk[i] <= LSB_cdb_value;
            r_pk[i] <= 1'b1;
          end
        end
      end

      ALU_valid <= w_sel_found;
      if (w_sel_found) begin
        ALU_op            <= r_op[w_sel_idx];
        ALU_Vj            <= r_vj[w_sel_idx];
        ALU_Vk            <= r_vk[w_sel_idx];
        ALU_imm           <= r_imm[w_sel_idx];
        ALU_curPC         <= r_pc[w_sel_idx];
        ALU_reorder       <= r_reorder[w_sel_idx];
        r_busy[w_sel_idx] <= 1'b0;
      end

      // The free slot is never busy, so it cannot collide with the dispatched slot.
      if (w_issue) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_op[w_free_idx]      <= issue_op;
        r_vj[w_free_idx]      <= w_in_vj;
        r_vk[w_free_idx]      <= w_in_vk;
        r_pj[w_free_idx]      <= w_in_pj;
        r_pk[w_free_idx]      <= w_in_pk;
        r_qj[w_free_idx]      <= Qj;
        r_qk[w_free_idx]      <= Qk;
        r_imm[w_free_idx]     <= issue_imm;
        r_pc[w_free_idx]      <= issue_curPC;
        r_reorder[w_free_idx] <= issue_reorder;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: reset, issue/dispatch, wake-up, bypass, stall, full, flush and select order.
module tb_reservation_station;

  localparam logic [4:0] OP_ADD = 5'd1;
`ifdef RS_AGE_SELECT_EN
  localparam logic [3:0] EXP_FIRST  = 4'd15;
  localparam logic [3:0] EXP_SECOND = 4'd1;
`else
  localparam logic [3:0] EXP_FIRST  = 4'd1;
  localparam logic [3:0] EXP_SECOND = 4'd15;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, jump_rst, RS_send;
  logic [31:0] Vj, Vk, issue_imm, issue_curPC;
  logic [3:0]  Qj, Qk, issue_reorder, ROB_head;
  logic        Pj, Pk;
  logic [4:0]  issue_op;
  logic        ALU_cdb_valid, LSB_cdb_valid;
  logic [3:0]  ALU_cdb_reorder, LSB_cdb_reorder;
  logic [31:0] ALU_cdb_value, LSB_cdb_value;
  logic        RS_full, ALU_valid;
  logic [4:0]  ALU_op;
  logic [31:0] ALU_Vj, ALU_Vk, ALU_imm, ALU_curPC;
  logic [3:0]  ALU_reorder;

  int n_vec = 0;
  int n_err = 0;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst), .RS_send(RS_send),
    .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk), .Pj(Pj), .Pk(Pk),
    .issue_op(issue_op), .issue_imm(issue_imm), .issue_curPC(issue_curPC),
    .issue_reorder(issue_reorder), .ROB_head(ROB_head),
    .ALU_cdb_valid(ALU_cdb_valid), .ALU_cdb_reorder(ALU_cdb_reorder), .ALU_cdb_value(ALU_cdb_value),
    .LSB_cdb_valid(LSB_cdb_valid), .LSB_cdb_reorder(LSB_cdb_reorder), .LSB_cdb_value(LSB_cdb_value),
    .RS_full(RS_full), .ALU_valid(ALU_valid), .ALU_op(ALU_op), .ALU_Vj(ALU_Vj), .ALU_Vk(ALU_Vk),
    .ALU_imm(ALU_imm), .ALU_curPC(ALU_curPC), .ALU_reorder(ALU_reorder)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; rdy = 1'b1; jump_rst = 1'b0; RS_send = 1'b0;
    Vj = '0; Vk = '0; Qj = '0; Qk = '0; Pj = 1'b1; Pk = 1'b1;
    issue_op = '0; issue_imm = '0; issue_curPC = '0; issue_reorder = '0; ROB_head = '0;
    ALU_cdb_valid = 1'b0; ALU_cdb_reorder = '0; ALU_cdb_value = '0;
    LSB_cdb_valid = 1'b0; LSB_cdb_reorder = '0; LSB_cdb_value = '0;
  endtask

  task automatic set_issue(input logic [31:0] vj, input logic pj, input logic [3:0] qj,
                           input logic [31:0] vk, input logic pk, input logic [3:0] qk,
                           input logic [3:0] reorder);
    RS_send = 1'b1; Vj = vj; Pj = pj; Qj = qj; Vk = vk; Pk = pk; Qk = qk;
    issue_op = OP_ADD; issue_reorder = reorder;
    issue_imm = 32'h10 + 32'(reorder); issue_curPC = 32'h1000 + 32'(reorder) * 4;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", ALU_valid); end
    n_vec++; if (RS_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0b want 0", RS_full); end
    n_vec++; if (ALU_Vj !== 32'h0) begin n_err++; $display("FAIL reset_vj: got %h want 0", ALU_Vj); end
    n_vec++; if (ALU_reorder !== 4'h0) begin n_err++; $display("FAIL reset_reorder: got %h want 0", ALU_reorder); end
  endtask

  task automatic test_basic_issue();
    set_issue(32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
    tick();
    RS_send = 1'b0;
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL basic_early: got %0b want 0", ALU_valid); end
    tick();
    n_vec++; if (ALU_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b want 1", ALU_valid); end
    n_vec++; if (ALU_Vj !== 32'd5) begin n_err++; $display("FAIL basic_vj: got %0d want 5", ALU_Vj); end
    n_vec++; if (ALU_Vk !== 32'd7) begin n_err++; $display("FAIL basic_vk: got %0d want 7", ALU_Vk); end
    n_vec++; if (ALU_reorder !== 4'd3) begin n_err++; $display("FAIL basic_reorder: got %0d want 3", ALU_reorder); end
    n_vec++; if (ALU_op !== OP_ADD) begin n_err++; $display("FAIL basic_op: got %0d want %0d", ALU_op, OP_ADD); end
    n_vec++; if (ALU_imm !== 32'h13) begin n_err++; $display("FAIL basic_imm: got %h want 13", ALU_imm); end
    n_vec++; if (ALU_curPC !== 32'h100c) begin n_err++; $display("FAIL basic_pc: got %h want 100c", ALU_curPC); end
    tick();
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL basic_one_shot: got %0b want 0", ALU_valid); end
    n_vec++; if (ALU_Vj !== 32'd5) begin n_err++; $display("FAIL basic_hold: got %0d want 5", ALU_Vj); end
  endtask

  task automatic test_wakeup();
    set_issue(32'd0, 1'b0, 4'd6, 32'd2, 1'b1, 4'd0, 4'd4);
    tick();
    RS_send = 1'b0;
    tick();
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL wake_wait: got %0b want 0", ALU_valid); end
    ALU_cdb_valid = 1'b1; ALU_cdb_reorder = 4'd6; ALU_cdb_value = 32'h1234;
    tick();
    ALU_cdb_valid = 1'b0;
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL wake_same_cycle: got %0b want 0", ALU_valid); end
    tick();
    n_vec++; if (ALU_valid !== 1'b1) begin n_err++; $display("FAIL wake_valid: got %0b want 1", ALU_valid); end
    n_vec++; if (ALU_Vj !== 32'h1234) begin n_err++; $display("FAIL wake_vj: got %h want 1234", ALU_Vj); end
    n_vec++; if (ALU_reorder !== 4'd4) begin n_err++; $display("FAIL wake_reorder: got %0d want 4", ALU_reorder); end
    tick();
  endtask

  task automatic test_issue_bypass();
    set_issue(32'hdead, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0, 4'd5);
    LSB_cdb_valid = 1'b1; LSB_cdb_reorder = 4'd2; LSB_cdb_value = 32'd9;
    tick();
    RS_send = 1'b0; LSB_cdb_valid = 1'b0;
    tick();
    n_vec++; if (ALU_valid !== 1'b1) begin n_err++; $display("FAIL bypass_valid: got %0b want 1", ALU_valid); end
    n_vec++; if (ALU_Vj !== 32'd9) begin n_err++; $display("FAIL bypass_vj: got %0d want 9", ALU_Vj); end
    set_issue(32'd0, 1'b0, 4'd3, 32'd0, 1'b0, 4'd3, 4'd7);
    ALU_cdb_valid = 1'b1; ALU_cdb_reorder = 4'd3; ALU_cdb_value = 32'd11;
    LSB_cdb_valid = 1'b1; LSB_cdb_reorder = 4'd3; LSB_cdb_value = 32'd22;
    tick();
    RS_send = 1'b0; ALU_cdb_valid = 1'b0; LSB_cdb_valid = 1'b0;
    tick();
    n_vec++; if (ALU_valid !== 1'b1) begin n_err++; $display("FAIL bypass_tie_valid: got %0b want 1", ALU_valid); end
    n_vec++; if (ALU_Vj !== 32'd11) begin n_err++; $display("FAIL bypass_tie_vj: got %0d want 11", ALU_Vj); end
    n_vec++; if (ALU_Vk !== 32'd11) begin n_err++; $display("FAIL bypass_tie_vk: got %0d want 11", ALU_Vk); end
    tick();
  endtask

  task automatic test_rdy_stall();
    set_issue(32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd6);
    tick();
    set_issue(32'd2, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd8);
    rdy = 1'b0;
    tick();
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid0: got %0b want 0", ALU_valid); end
    tick();
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid1: got %0b want 0", ALU_valid); end
    RS_send = 1'b0; rdy = 1'b1;
    tick();
    n_vec++; if (ALU_valid !== 1'b1) begin n_err++; $display("FAIL stall_resume: got %0b want 1", ALU_valid); end
    n_vec++; if (ALU_reorder !== 4'd6) begin n_err++; $display("FAIL stall_reorder: got %0d want 6", ALU_reorder); end
    tick();
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL stall_dropped: got %0b want 0", ALU_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      set_issue(32'd0, 1'b0, 4'(i), 32'd3, 1'b1, 4'd0, 4'(i));
      tick();
    end
    n_vec++; if (RS_full !== 1'b1) begin n_err++; $display("FAIL full_set: got %0b want 1", RS_full); end
    set_issue(32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd10);
    tick();
    RS_send = 1'b0;
    n_vec++; if (RS_full !== 1'b1) begin n_err++; $display("FAIL full_hold: got %0b want 1", RS_full); end
    tick();
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL full_17th_ignored: got %0b want 0", ALU_valid); end
    ALU_cdb_valid = 1'b1; ALU_cdb_reorder = 4'd9; ALU_cdb_value = 32'h99;
    tick();
    ALU_cdb_valid = 1'b0;
    n_vec++; if (RS_full !== 1'b1) begin n_err++; $display("FAIL full_before_dispatch: got %0b want 1", RS_full); end
    tick();
    n_vec++; if (ALU_valid !== 1'b1) begin n_err++; $display("FAIL full_wake_valid: got %0b want 1", ALU_valid); end
    n_vec++; if (ALU_reorder !== 4'd9) begin n_err++; $display("FAIL full_wake_reorder: got %0d want 9", ALU_reorder); end
    n_vec++; if (ALU_Vj !== 32'h99) begin n_err++; $display("FAIL full_wake_vj: got %h want 99", ALU_Vj); end
    n_vec++; if (RS_full !== 1'b0) begin n_err++; $display("FAIL full_drop: got %0b want 0", RS_full); end
  endtask

  task automatic test_flush();
    ALU_cdb_valid = 1'b1; ALU_cdb_reorder = 4'd3; ALU_cdb_value = 32'h33;
    tick();
    ALU_cdb_valid = 1'b0;
    jump_rst = 1'b1;
    set_issue(32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd12);
    tick();
    jump_rst = 1'b0; RS_send = 1'b0;
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_dispatch: got %0b want 0", ALU_valid); end
    n_vec++; if (RS_full !== 1'b0) begin n_err++; $display("FAIL flush_full: got %0b want 0", RS_full); end
    tick();
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL flush_send_dropped: got %0b want 0", ALU_valid); end
    for (int t = 0; t < 16; t++) begin
      ALU_cdb_valid = 1'b1; ALU_cdb_reorder = 4'(t); ALU_cdb_value = 32'(t);
      tick();
      n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL flush_cdb_tag%0d: got %0b want 0", t, ALU_valid); end
    end
    ALU_cdb_valid = 1'b0;
    tick();
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL flush_tail: got %0b want 0", ALU_valid); end
  endtask

  task automatic test_select_order();
    ROB_head = 4'd14;
    set_issue(32'd0, 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 4'd1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      set_issue(32'd0, 1'b0, 4'd11, 32'd0, 1'b1, 4'd0, 4'(i + 1));
      tick();
    end
    set_issue(32'd0, 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 4'd15);
    tick();
    RS_send = 1'b0;
    ALU_cdb_valid = 1'b1; ALU_cdb_reorder = 4'd10; ALU_cdb_value = 32'h5a;
    tick();
    ALU_cdb_valid = 1'b0;
    tick();
    n_vec++; if (ALU_valid !== 1'b1) begin n_err++; $display("FAIL sel_first_valid: got %0b want 1", ALU_valid); end
    n_vec++; if (ALU_reorder !== EXP_FIRST) begin n_err++; $display("FAIL sel_first: got %0d want %0d", ALU_reorder, EXP_FIRST); end
    tick();
    n_vec++; if (ALU_valid !== 1'b1) begin n_err++; $display("FAIL sel_second_valid: got %0b want 1", ALU_valid); end
    n_vec++; if (ALU_reorder !== EXP_SECOND) begin n_err++; $display("FAIL sel_second: got %0d want %0d", ALU_reorder, EXP_SECOND); end
    tick();
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL sel_gap: got %0b want 0", ALU_valid); end
    ALU_cdb_valid = 1'b1; ALU_cdb_reorder = 4'd11; ALU_cdb_value = 32'h77;
    tick();
    ALU_cdb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (ALU_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d: got %0b want 1", i, ALU_valid); end
      n_vec++; if (ALU_reorder !== 4'(i + 2)) begin n_err++; $display("FAIL b2b_reorder%0d: got %0d want %0d", i, ALU_reorder, i + 2); end
    end
    tick();
    n_vec++; if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %0b want 0", ALU_valid); end
    n_vec++; if (RS_full !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %0b want 0", RS_full); end
    ROB_head = 4'd0;
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_issue_bypass();
    test_rdy_stall();
    test_full();
    test_flush();
    test_select_order();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
